// File: rtl/w_stream_serializer.sv
// w_stream_serializer: buffers WIDTH-bit words in a DEPTH-entry FIFO and shifts
// each one out MSB-first on w, one bit per clock, for the w-sequence detector.
// Back-to-back words form a contiguous bit stream. While no word is being
// shifted, w carries IDLE_BIT.
// Optional feature: define SER_PARITY_EN to append one even-parity bit after
// each word's LSB. This adds a PARITY state to the shifter.
//
// Handshake: a word is written on any rising edge where in_valid && in_ready.
// in_ready is driven only from registered FIFO pointers, so a pop never reaches
// it combinationally. A sender facing in_ready=0 keeps in_data/in_valid stable.
module w_stream_serializer #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter bit IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             w,
    output logic             frame_start,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
`ifdef SER_PARITY_EN
        ,
        ST_PARITY = 2'd2
`endif
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] rd_data;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bitcnt;
    logic             par;
    logic             busy_q;
    logic             last_bit;

    // FIFO status comes straight from the registered pointers
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign last_bit = (bitcnt == BW'(WIDTH - 1));

    // Pop whenever the shifter is ready for a new word and one is waiting
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE:   pop = !empty;
`ifdef SER_PARITY_EN
            ST_SHIFT:  pop = 1'b0;
            ST_PARITY: pop = !empty;
`else
            ST_SHIFT:  pop = last_bit && !empty;
`endif
            default:   pop = 1'b0;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // FIFO pointers, wrapping modulo 2*DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Shifter FSM with registered w / frame_start; reload on the last bit keeps the stream gapless
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            par         <= 1'b0;
            w           <= IDLE_BIT;
            frame_start <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    w           <= IDLE_BIT;
                    frame_start <= 1'b0;
                    busy_q      <= 1'b0;
                    if (pop) begin
                        shreg  <= rd_data;
                        par    <= ^rd_data;
                        bitcnt <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    w           <= shreg[WIDTH-1];
                    frame_start <= (bitcnt == '0);
                    busy_q      <= 1'b1;
                    shreg       <= {shreg[WIDTH-2:0], 1'b0};
                    bitcnt      <= bitcnt + BW'(1);
                    if (last_bit) begin
`ifdef SER_PARITY_EN
                        state <= ST_PARITY;
`else
                        if (pop) begin
                            shreg  <= rd_data;
                            par    <= ^rd_data;
                            bitcnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
`endif
                    end
                end
`ifdef SER_PARITY_EN
                ST_PARITY: begin
                    w           <= par;
                    frame_start <= 1'b0;
                    busy_q      <= 1'b1;
                    if (pop) begin
                        shreg  <= rd_data;
                        par    <= ^rd_data;
                        bitcnt <= '0;
                        state  <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // busy_q covers the cycle w still shows the final bit after the FSM has gone idle
    assign busy      = busy_q || (state != ST_IDLE) || !empty;
    assign dbg_state = state;

endmodule

// File: tb/tb_w_stream_serializer.sv
// Testbench for w_stream_serializer (WIDTH=8, DEPTH=4, IDLE_BIT=0).
// Define SER_PARITY_EN to expect a trailing even-parity bit in each frame.
// Reference model: every accepted word schedules its bits at absolute cycle
// numbers. A frame starts at max(accept_edge + 2, end of the previous frame).
// The model tracks pop/end times per word to predict busy and in_ready.
module tb_w_stream_serializer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam bit IDLE_BIT = 1'b0;
`ifdef SER_PARITY_EN
  localparam int LEN = WIDTH + 1;
`else
  localparam int LEN = WIDTH;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic w;
  logic frame_start;
  logic busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  w_stream_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_BIT(IDLE_BIT)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .w(w),
    .frame_start(frame_start),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [33:0] exp_q[$];  // {stamp[31:0], frame_start, bit}
  int pop_q[$];
  int end_q[$];
  int prev_end = 0;
  bit mon_en = 1'b0;
  int checks = 0;
  int failures = 0;

  task automatic check_bit(input string name, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0b expected=%0b", name, k, act, exp);
    end
  endtask

  // monitor: compares outputs every cycle, then records any acceptance at the coming edge
  always @(negedge clk) begin : monitor
    int k;
    int start;
    int fifo_n;
    logic ew;
    logic efs;
    logic eb;
    logic er;
    if (mon_en) begin
      k = cyc;
      ew = IDLE_BIT;
      efs = 1'b0;
      if (exp_q.size() > 0 && int'(exp_q[0][33:2]) == k) begin
        ew = exp_q[0][0];
        efs = exp_q[0][1];
        void'(exp_q.pop_front());
      end
      while (end_q.size() > 0 && end_q[0] <= k) begin
        void'(end_q.pop_front());
        void'(pop_q.pop_front());
      end
      fifo_n = 0;
      foreach (pop_q[i]) if (pop_q[i] > k) fifo_n++;
      eb = (end_q.size() > 0);
      er = (fifo_n < DEPTH);
      check_bit("w", k, w, ew);
      check_bit("frame_start", k, frame_start, efs);
      check_bit("busy", k, busy, eb);
      check_bit("in_ready", k, in_ready, er);

      if (reset) begin
        exp_q.delete();
        pop_q.delete();
        end_q.delete();
        prev_end = 0;
      end else if (in_valid && in_ready) begin
        start = (k + 3 > prev_end) ? k + 3 : prev_end;
        for (int i = 0; i < WIDTH; i++) begin
          exp_q.push_back({32'(start + i), (i == 0), in_data[WIDTH-1-i]});
        end
`ifdef SER_PARITY_EN
        exp_q.push_back({32'(start + WIDTH), 1'b0, ^in_data});
`endif
        pop_q.push_back(start - 1);
        end_q.push_back(start + LEN);
        prev_end = start + LEN;
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    int n;
    in_data = d;
    in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout cyc=%0d actual in_ready=0 expected in_ready=1", cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // stimulus
  initial begin : stim
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // single word after reset
    send(8'hB4);
    idle(14);

    // back-to-back extremes
    send(8'hFF);
    send(8'h00);
    idle(20);

    // six words held against a filling FIFO
    for (int i = 0; i < 6; i++) send(8'(8'h11 * (i + 1)));
    idle(60);

    // reset partway through a frame with words queued
    send(8'hA5);
    send(8'h3C);
    send(8'hC3);
    idle(2);
    pulse_reset();
    idle(30);

    // random traffic with random gaps
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
      send(8'($urandom_range(0, 255)));
      if (i == 90) begin
        idle($urandom_range(0, 10));
        pulse_reset();
      end
    end

    // drain
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual pending=%0d expected pending=0", exp_q.size());
    end
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
